// File: rtl/lif_chain.sv
// Chain of leaky integrate-and-fire neurons; neuron k>0 is driven by the registered spike of neuron k-1.
// Optional feature: define LIF_REFRAC_EN to enable per-neuron refractory counters.
module lif_chain #(
  parameter int N_NEURONS  = 3,
  parameter int W          = 8,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 2,
  parameter int WEIGHT     = 200,
  parameter int REFRAC     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [W-1:0]         isyn,
  input  logic [3:0]           sel,
  input  logic                 cnt_clr,
  output logic [N_NEURONS-1:0] spike,
  output logic [W-1:0]         vmem,
  output logic [15:0]          spike_cnt
);

  localparam logic [W:0]   SAT      = {1'b0, {W{1'b1}}};
  localparam logic [W:0]   THRESH_W = (W+1)'(THRESH);
  localparam logic [W-1:0] WEIGHT_W = W'(WEIGHT);

  logic [W-1:0]         v        [N_NEURONS];
  logic [W-1:0]         v_nxt    [N_NEURONS];
  logic [W-1:0]         inp      [N_NEURONS];
  logic [W:0]           sum      [N_NEURONS];
  logic [N_NEURONS-1:0] spike_nxt;
  logic [N_NEURONS-1:0] upstream;

`ifdef LIF_REFRAC_EN
  localparam logic [3:0] REFRAC_W = 4'(REFRAC);
  logic [3:0] refr     [N_NEURONS];
  logic [3:0] refr_nxt [N_NEURONS];
`endif

  // Bit k carries spike[k-1]; bit 0 is unused because neuron 0 is fed by isyn.
  assign upstream = spike << 1;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    spike_nxt = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      v_nxt[k] = '0;
`ifdef LIF_REFRAC_EN
      refr_nxt[k] = '0;
`endif
      inp[k] = (k == 0) ? isyn : (upstream[k] ? WEIGHT_W : '0);
      // V - (V>>LEAK_SHIFT) never goes negative, so only the top end needs saturation.
      sum[k] = {1'b0, v[k]} - {1'b0, (v[k] >> LEAK_SHIFT)} + {1'b0, inp[k]};
      if (sum[k] > SAT) sum[k] = SAT;
`ifdef LIF_REFRAC_EN
      if (refr[k] != 4'd0) begin
        refr_nxt[k] = refr[k] - 4'd1;
      end else if (sum[k] >= THRESH_W) begin
        spike_nxt[k] = 1'b1;
        refr_nxt[k]  = REFRAC_W;
      end else begin
        v_nxt[k] = sum[k][W-1:0];
      end
`else
      if (sum[k] >= THRESH_W) spike_nxt[k] = 1'b1;
      else                    v_nxt[k]     = sum[k][W-1:0];
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every neuron sees the pre-edge spike of its neighbour.
  // NOTE: the membrane and refractory arrays are small registers, not RAM, so they are reset like any other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v[k] <= '0;
`ifdef LIF_REFRAC_EN
        refr[k] <= '0;
`endif
      end
    end else if (ena) begin
      spike <= spike_nxt;
      for (int k = 0; k < N_NEURONS; k++) begin
        v[k] <= v_nxt[k];
`ifdef LIF_REFRAC_EN
        refr[k] <= refr_nxt[k];
`endif
      end
    end
  end

  // Clear wins over increment and works even while updates are frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                spike_cnt <= '0;
    else if (cnt_clr)                       spike_cnt <= '0;
    else if (ena && spike_nxt[N_NEURONS-1]) spike_cnt <= spike_cnt + 16'd1;
  end

  always_comb begin
    vmem = '0;
    for (int k = 0; k < N_NEURONS; k++)
      if (sel == 4'(k)) vmem = v[k];
  end

endmodule

// File: doc/lif_chain.md
LIF_CHAIN -- requirements
Module: lif_chain

Interface
REQ-001 SHALL have parameter N_NEURONS, default 3, number of chained neurons (1..16).
REQ-002 SHALL have parameter W, default 8, membrane and input width in bits (4..16).
REQ-003 SHALL have parameter THRESH, default 200, firing threshold (1..2^W-1).
REQ-004 SHALL have parameter LEAK_SHIFT, default 2, leak term is V>>LEAK_SHIFT (1..W-1).
REQ-005 SHALL have parameter WEIGHT, default 200, synaptic input to neuron k>0 while spike[k-1]=1 (0..2^W-1).
REQ-006 SHALL have parameter REFRAC, default 3, refractory cycles after a spike (0..15).
REQ-007 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port ena  input  1  update enable; low freezes all state.
REQ-010 SHALL have port isyn  input  W  synaptic current into neuron 0.
REQ-011 SHALL have port sel  input  4  neuron index for membrane readout.
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of spike_cnt.
REQ-013 SHALL have port spike  output  N_NEURONS  registered spike flags, one per neuron.
REQ-014 SHALL have port vmem  output  W  membrane of neuron sel, combinational mux of registers; 0 if sel>=N_NEURONS.
REQ-015 SHALL have port spike_cnt  output  16  count of spikes of neuron N_NEURONS-1.

Function
REQ-016 SHALL, per enabled cycle, compute per neuron sum = V - (V>>LEAK_SHIFT) + I in W+1 bits, saturating at 2^W-1.
REQ-017 SHALL use I = isyn for neuron 0 and I = spike[k-1] ? WEIGHT : 0 for neuron k>0 (one cycle per stage).
REQ-018 SHALL, if not refractory and sum >= THRESH, set spike[k]=1 for exactly that next cycle, load V=0 and load refractory counter with REFRAC.
REQ-019 SHALL, if not refractory and sum < THRESH, load V=sum and spike[k]=0.
REQ-020 SHALL, while refractory counter >0, hold V=0, spike[k]=0, ignore I, decrement counter by one per enabled cycle.
REQ-021 SHALL, with REFRAC=0, allow a spike on the cycle immediately after a previous spike.
REQ-022 SHALL, when ena=0, hold V, spike, refractory counters and spike_cnt unchanged.
REQ-023 SHALL increment spike_cnt on each enabled cycle where the registered next value of spike[N_NEURONS-1] is 1, wrapping 0xFFFF->0x0000.
REQ-024 SHALL give cnt_clr priority over increment (simultaneous clear and spike -> 0); cnt_clr acts regardless of ena.

Reset
REQ-025 SHALL, on rst=1 at any time, immediately force all V=0, spike=0, refractory counters=0, spike_cnt=0; mid-refractory state is discarded.
REQ-026 SHALL resume updating on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, when macro LIF_REFRAC_EN is defined, implement refractory counters per REQ-018/REQ-020.
REQ-028 SHALL, when LIF_REFRAC_EN is undefined, omit refractory counters and behave as REFRAC=0 regardless of parameter value.

Verification (defaults, LIF_REFRAC_EN defined unless stated)
REQ-029 SHALL cover: isyn=100 constant from reset -> V0 100,175, then spike[0]=1 on cycle 3, V0=0, refractory cycles 4-6, next spike cycle 9.
REQ-030 SHALL cover: isyn=40 constant -> V0 converges to 160, spike[0] never asserts over 100 cycles.
REQ-031 SHALL cover: isyn=255 -> sum saturates at 255, spike[0]=1 cycle 1; spike[1]=1 cycle 2; spike[2]=1 cycle 3; spike_cnt=1.
REQ-032 SHALL cover: ena=0 for 5 cycles mid-integration -> vmem constant; cnt_clr with simultaneous spike[2] -> spike_cnt=0.
REQ-033 SHALL cover: rst pulse during refractory -> all outputs 0 asynchronously; LIF_REFRAC_EN undefined with isyn=255 -> spike[0]=1 every cycle.
